swp_sequencer: RTL and testbench

- Multi-cycle sequencer for the SWP instruction (opcode 6'b111111), sitting beside the decoder in the ID stage.
- Expands one SWP into two back-to-back micro-ops (FIRST, SECOND) with register-file swap-select and write-back control.
- Freezes the PC and IF/ID so SWP stays in ID for both micro-ops.
- Honours hazard stalls and branch flushes, and keeps a completed-swap counter.
- When uop_valid=1, the ID/EXE mux takes its exec_cmd and wb_en from this block; otherwise it takes them from the decoder.

---
 rtl/swp_sequencer.sv | 177 +++++++++++++++++
 tb/tb_swp_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/swp_sequencer.sv
// ---------------------------------------------------------------------------
// swp_sequencer
//
// Sits beside the instruction decoder in the ID stage. It expands one SWP
// instruction into two back-to-back micro-ops: FIRST, then SECOND. For each
// micro-op it drives the register-file swap select and the write-back enable.
// While the first micro-op issues it freezes the PC and the IF/ID register,
// so that SWP stays in ID for both micro-ops. Hazard stalls and branch
// flushes are honoured, and the block counts completed swaps.
//
// When uop_valid is high, the ID/EXE mux takes exec_cmd and wb_en from this
// block instead of from the decoder.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   opcode[5:0]   in   opcode of the instruction currently in ID
//   id_valid      in   ID holds a real (non-bubble) instruction
//   hazard_stall  in   hazard unit requests ID hold this cycle
//   flush         in   taken branch in EXE; kill the ID contents
//   freeze        out  hold PC and IF/ID register
//   uop_valid     out  micro-op outputs are valid and override the decoder
//   uop_exec_cmd  out  ALU command for the current micro-op
//   swp_sel[1:0]  out  swap select: 01 = first, 10 = second, 00 = none
//   uop_wb_en     out  write-back enable for the current micro-op
//   busy          out  sequencer is mid-SWP (state SECOND)
//   swp_count     out  number of completed SWPs; wraps at all-ones
//
// All outputs except swp_count are combinational from the state and the
// inputs. They are held at zero for as long as rst is high, without waiting
// for a clock edge.
// ---------------------------------------------------------------------------
module swp_sequencer #(
    parameter logic [5:0] SWP_OPCODE = 6'b111111,
    parameter logic [3:0] FIRST_CMD  = 4'b1100,
    parameter logic [3:0] SECOND_CMD = 4'b1101,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             id_valid,
    input  logic             hazard_stall,
    input  logic             flush,
    output logic             freeze,
    output logic             uop_valid,
    output logic [3:0]       uop_exec_cmd,
    output logic [1:0]       swp_sel,
    output logic             uop_wb_en,
    output logic             busy,
    output logic [CNT_W-1:0] swp_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_FIRST  = 2'b01;
    localparam logic [1:0] SEL_SECOND = 2'b10;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] count_r;

    logic             det_s;
    logic             inc_s;
    logic             freeze_s;
    logic             uop_valid_s;
    logic [3:0]       uop_exec_cmd_s;
    logic [1:0]       swp_sel_s;
    logic             uop_wb_en_s;
    logic             busy_s;

    // A SWP can start only when it is a real instruction and is neither being
    // held by the hazard unit nor killed by a branch in EXE.
    assign det_s = id_valid & (opcode == SWP_OPCODE) & ~hazard_stall & ~flush;

    // State register. Reset returns to IDLE at once, so a SECOND micro-op
    // that is still pending is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and micro-op decode. In SECOND, opcode and id_valid are
    // not looked at: IF/ID was frozen during FIRST, so they still describe
    // the same SWP.
    always_comb begin
        next_state_s   = state_r;
        freeze_s       = 1'b0;
        uop_valid_s    = 1'b0;
        uop_exec_cmd_s = 4'b0000;
        swp_sel_s      = SEL_NONE;
        uop_wb_en_s    = 1'b0;
        inc_s          = 1'b0;
        busy_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (det_s) begin
                    // Freeze PC and IF/ID so SWP is still in ID next cycle.
                    uop_valid_s    = 1'b1;
                    uop_exec_cmd_s = FIRST_CMD;
                    swp_sel_s      = SEL_FIRST;
                    uop_wb_en_s    = 1'b1;
                    freeze_s       = 1'b1;
                    next_state_s   = SECOND;
                end else begin
                    // The hazard unit ORs its own freeze in externally.
                    next_state_s   = IDLE;
                end
            end
            SECOND: begin
                busy_s = 1'b1;
                if (flush) begin
                    // The branch kills SWP: nothing issues and nothing is counted.
                    next_state_s = IDLE;
                end else if (hazard_stall) begin
                    // Hold SWP in ID and issue a bubble until the hazard clears.
                    freeze_s     = 1'b1;
                    next_state_s = SECOND;
                end else begin
                    // No freeze here, so the next instruction enters ID on
                    // the same edge that completes the swap.
                    uop_valid_s    = 1'b1;
                    uop_exec_cmd_s = SECOND_CMD;
                    swp_sel_s      = SEL_SECOND;
                    uop_wb_en_s    = 1'b1;
                    inc_s          = 1'b1;
                    next_state_s   = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output gating: rst forces every output to zero immediately, including
    // the combinational ones, without waiting for the state register.
    always_comb begin
        if (rst) begin
            freeze       = 1'b0;
            uop_valid    = 1'b0;
            uop_exec_cmd = 4'b0000;
            swp_sel      = SEL_NONE;
            uop_wb_en    = 1'b0;
            busy         = 1'b0;
        end else begin
            freeze       = freeze_s;
            uop_valid    = uop_valid_s;
            uop_exec_cmd = uop_exec_cmd_s;
            swp_sel      = swp_sel_s;
            uop_wb_en    = uop_wb_en_s;
            busy         = busy_s;
        end
    end

    // Completed-swap counter. It advances only when SECOND actually issues,
    // and it wraps naturally from all-ones to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign swp_count = count_r;

endmodule

// File: tb/tb_swp_sequencer.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for swp_sequencer.
//
// Inputs are driven just after the falling edge, and the outputs are sampled
// 1 ns later, well away from the rising edge. A second instance with an 8-bit
// counter shares all the inputs, so that counter wrap can be reached in a
// short run.
// ---------------------------------------------------------------------------
module tb_swp_sequencer;

    localparam logic [5:0] SWP = 6'b111111;
    localparam logic [5:0] ADD = 6'b000001;
    localparam logic [3:0] C1  = 4'b1100;
    localparam logic [3:0] C2  = 4'b1101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'b000000;
    logic        id_valid = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        flush = 1'b0;

    logic        freeze, uop_valid, uop_wb_en, busy;
    logic [3:0]  uop_exec_cmd;
    logic [1:0]  swp_sel;
    logic [15:0] swp_count;

    logic        w_freeze, w_uop_valid, w_uop_wb_en, w_busy;
    logic [3:0]  w_uop_exec_cmd;
    logic [1:0]  w_swp_sel;
    logic [7:0]  w_swp_count;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    swp_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .id_valid(id_valid),
        .hazard_stall(hazard_stall), .flush(flush), .freeze(freeze),
        .uop_valid(uop_valid), .uop_exec_cmd(uop_exec_cmd), .swp_sel(swp_sel),
        .uop_wb_en(uop_wb_en), .busy(busy), .swp_count(swp_count)
    );

    swp_sequencer #(.CNT_W(8)) dut_w (
        .clk(clk), .rst(rst), .opcode(opcode), .id_valid(id_valid),
        .hazard_stall(hazard_stall), .flush(flush), .freeze(w_freeze),
        .uop_valid(w_uop_valid), .uop_exec_cmd(w_uop_exec_cmd), .swp_sel(w_swp_sel),
        .uop_wb_en(w_uop_wb_en), .busy(w_busy), .swp_count(w_swp_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic fz, input logic uv,
                        input logic [3:0] cmd, input logic [1:0] sel,
                        input logic wb, input logic bz);
        chk({tag, ".freeze"}, {31'd0, freeze}, {31'd0, fz});
        chk({tag, ".uop_valid"}, {31'd0, uop_valid}, {31'd0, uv});
        chk({tag, ".exec_cmd"}, {28'd0, uop_exec_cmd}, {28'd0, cmd});
        chk({tag, ".swp_sel"}, {30'd0, swp_sel}, {30'd0, sel});
        chk({tag, ".wb_en"}, {31'd0, uop_wb_en}, {31'd0, wb});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic hs, input logic fl);
        @(negedge clk);
        id_valid     = v;
        opcode       = op;
        hazard_stall = hs;
        flush        = fl;
        #1;
    endtask

    task automatic cnt(input string tag);
        chk(tag, {16'd0, swp_count}, {16'd0, exp_count});
    endtask

    initial begin
        // Reset held, with a SWP sitting in ID: every output must stay zero.
        id_valid = 1'b1;
        opcode   = SWP;
        #2;
        outs("rst_hold", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        cnt("rst_count");
        drive(1'b0, ADD, 1'b0, 1'b0);
        rst = 1'b0;

        // Single SWP.
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("single_c0", 1'b1, 1'b1, C1, 2'b01, 1'b1, 1'b0);
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("single_c1", 1'b0, 1'b1, C2, 2'b10, 1'b1, 1'b1);
        exp_count = exp_count + 16'd1;
        drive(1'b0, ADD, 1'b0, 1'b0);
        outs("single_c2", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        cnt("single_count");

        // Two back-to-back SWPs, with no bubble between them.
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("b2b_0", 1'b1, 1'b1, C1, 2'b01, 1'b1, 1'b0);
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("b2b_1", 1'b0, 1'b1, C2, 2'b10, 1'b1, 1'b1);
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("b2b_2", 1'b1, 1'b1, C1, 2'b01, 1'b1, 1'b0);
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("b2b_3", 1'b0, 1'b1, C2, 2'b10, 1'b1, 1'b1);
        exp_count = exp_count + 16'd2;
        drive(1'b0, ADD, 1'b0, 1'b0);
        cnt("b2b_count");

        // Hazard stall for 3 cycles while in SECOND.
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("stall_first", 1'b1, 1'b1, C1, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SWP, 1'b1, 1'b0);
            outs($sformatf("stall_%0d", i), 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
        end
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("stall_second", 1'b0, 1'b1, C2, 2'b10, 1'b1, 1'b1);
        exp_count = exp_count + 16'd1;
        drive(1'b0, ADD, 1'b0, 1'b0);
        outs("stall_after", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        cnt("stall_count");

        // Flush while in SECOND: the second micro-op is never issued.
        drive(1'b1, SWP, 1'b0, 1'b0);
        outs("flush_first", 1'b1, 1'b1, C1, 2'b01, 1'b1, 1'b0);
        drive(1'b1, SWP, 1'b0, 1'b1);
        outs("flush_second", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
        drive(1'b0, ADD, 1'b0, 1'b0);
        outs("flush_after", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        cnt("flush_count");

        // Flush in the IDLE detect cycle: nothing issues.
        drive(1'b1, SWP, 1'b0, 1'b1);
        outs("flush_idle", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        drive(1'b0, ADD, 1'b0, 1'b0);
        outs("flush_idle_next", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);

        // Cases that must not start a SWP.
        drive(1'b1, ADD, 1'b0, 1'b0);
        outs("add_op", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        drive(1'b1, SWP, 1'b1, 1'b0);
        outs("idle_stall", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        drive(1'b0, SWP, 1'b0, 1'b0);
        outs("not_valid", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        drive(1'b0, ADD, 1'b0, 1'b0);
        outs("no_start_after", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        cnt("no_start_count");

        // Asynchronous reset pulsed mid-SWP.
        drive(1'b1, SWP, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        outs("mid_rst", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        exp_count = 16'd0;
        cnt("mid_rst_count");
        drive(1'b0, ADD, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        outs("post_rst", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        drive(1'b0, ADD, 1'b0, 1'b0);
        outs("post_rst_idle", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        cnt("post_rst_count");

        // Counter wrap, checked on the 8-bit instance (all-ones is 255).
        while (exp_count < 16'd255) begin
            drive(1'b1, SWP, 1'b0, 1'b0);
            drive(1'b1, SWP, 1'b0, 1'b0);
            exp_count = exp_count + 16'd1;
        end
        drive(1'b0, ADD, 1'b0, 1'b0);
        chk("wrap_full", {24'd0, w_swp_count}, 32'h0000_00FF);
        cnt("wide_255");
        drive(1'b1, SWP, 1'b0, 1'b0);
        drive(1'b1, SWP, 1'b0, 1'b0);
        exp_count = exp_count + 16'd1;
        drive(1'b0, ADD, 1'b0, 1'b0);
        chk("wrap_zero", {24'd0, w_swp_count}, 32'h0000_0000);
        cnt("wide_256");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
